// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI register map, status layout and mode constants
//
// Purpose: constants shared by the SPI slave port (and the SPI master
// peripheral): register addresses, status bit positions, SPI mode, FSM states.
package spi_pkg;

  // Register map
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  // Status bit positions (control uses the same positions as irq enables)
  localparam int ST_RRDY  = 7;
  localparam int ST_TRDY  = 6;
  localparam int ST_TUR   = 4;
  localparam int ST_ROE   = 3;
  localparam int ST_FE    = 2;
  localparam int ST_SSACT = 0;

  // SPI mode: CPOL=0, CPHA=0, 8-bit, MSB first
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam int SPI_DATA_BITS = 8;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

  function automatic logic [15:0] pack_status(input logic rrdy, input logic trdy,
                                              input logic tur, input logic roe,
                                              input logic fe, input logic ssact);
    logic [15:0] w;
    w           = '0;
    w[ST_RRDY]  = rrdy;
    w[ST_TRDY]  = trdy;
    w[ST_TUR]   = tur;
    w[ST_ROE]   = roe;
    w[ST_FE]    = fe;
    w[ST_SSACT] = ssact;
    return w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - synchronizer plus edge detector for one async input
//
// Purpose: brings an asynchronous pin into clk through SYNC_STAGES flops and
// one history flop, and produces single-cycle rise/fall pulses.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   i_async      : asynchronous input pin
//   o_sync       : synchronized level
//   o_rise       : pulse, synchronized level went 0 -> 1
//   o_fall       : pulse, synchronized level went 1 -> 0
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_hist;
  assign o_fall = ~o_sync & r_hist;

endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI mode-0 slave with Avalon-MM register port
//
// Purpose: responds to an external SPI master (8-bit, MSB first). SCLK, SS_n
// and MOSI are oversampled in clk; there is no SCLK clock domain.
// Ports:
//   clk, reset_n        : system clock, asynchronous active-low reset
//   SCLK, SS_n, MOSI    : SPI pins from the master (asynchronous)
//   MISO, MISO_oe       : slave data out and its tri-state enable
//   mem_addr            : register address (0 rx, 1 tx, 2 status, 3 control)
//   data_from_cpu       : write data
//   data_to_cpu         : read data, valid the cycle after the read request
//   read_n, write_n     : active-low strobes, qualified by spi_select
//   irq                 : registered interrupt
//   dataavailable       : RRDY
//   readyfordata        : TRDY
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  // Mode 0: sample MOSI on the rising edge, launch MISO on the falling edge.
  localparam bit SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  // Synchronized pins and edges
  logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
  logic w_s_ss, w_ss_end, w_ss_start;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_s_mosi, w_sample, w_launch;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .i_async(SCLK),
    .o_sync(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .i_async(SS_n),
    .o_sync(w_s_ss), .o_rise(w_ss_end), .o_fall(w_ss_start)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
  end

  assign w_s_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_sample = SAMPLE_ON_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_launch = SAMPLE_ON_RISE ? w_sclk_fall : w_sclk_rise;

  // State and datapath registers
  spi_state_e  r_state, w_state_n;
  logic [7:0]  r_tx_shift, w_tx_next, w_tx_src;
  logic [6:0]  r_rx_shift;
  logic [2:0]  r_bit_cnt, w_cnt_after;
  logic        r_reload_pending;
  logic [7:0]  r_tx_holding, r_rx_holding;
  logic        r_tx_primed, r_rrdy, r_roe, r_tur, r_fe;
  logic [15:0] r_control, r_data_to_cpu, w_status, w_rd_data;
  logic        r_miso, r_miso_oe, r_irq;

  // FSM strobes
  logic w_load_tx, w_shift_tx, w_rx_en, w_byte_done, w_frame_end, w_abort;

  // Register port decode
  logic w_wr, w_rd, w_wr_tx, w_wr_status, w_wr_ctrl, w_rd_rx;
  assign w_wr        = spi_select & ~write_n;
  assign w_rd        = spi_select & ~read_n;
  assign w_wr_tx     = w_wr && (mem_addr == ADDR_TXDATA);
  assign w_wr_status = w_wr && (mem_addr == ADDR_STATUS);
  assign w_wr_ctrl   = w_wr && (mem_addr == ADDR_CONTROL);
  assign w_rd_rx     = w_rd && (mem_addr == ADDR_RXDATA);

  // Bit count as it stands after this cycle's sample edge; an ss_end that
  // coincides with the 8th sample edge therefore closes a complete byte.
  assign w_cnt_after = w_sample ? r_bit_cnt + 3'd1 : r_bit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SPI_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_load_tx   = 1'b0;
    w_shift_tx  = 1'b0;
    w_rx_en     = 1'b0;
    w_byte_done = 1'b0;
    w_frame_end = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      SPI_IDLE: begin
        if (w_ss_start) begin
          w_state_n = SPI_SHIFT;
          w_load_tx = 1'b1;
        end
      end
      SPI_SHIFT: begin
        if (w_sample) begin
          w_rx_en     = 1'b1;
          w_byte_done = (r_bit_cnt == 3'(SPI_DATA_BITS - 1));
        end
        if (w_launch) begin
          w_load_tx  = r_reload_pending;
          w_shift_tx = ~r_reload_pending;
        end
        if (w_ss_end) begin
          w_state_n   = SPI_IDLE;
          w_frame_end = 1'b1;
          w_abort     = (w_cnt_after != 3'd0);
        end
      end
      default: w_state_n = SPI_IDLE;
    endcase
  end

  // Underrun substitutes IDLE_BYTE when the CPU has not primed a byte.
  assign w_tx_src = r_tx_primed ? r_tx_holding : IDLE_BYTE;

  always_comb begin
    w_tx_next = r_tx_shift;
    if (w_load_tx)       w_tx_next = w_tx_src;
    else if (w_shift_tx) w_tx_next = {r_tx_shift[6:0], 1'b0};
  end

  // Shift engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_shift       <= '0;
      r_rx_shift       <= '0;
      r_bit_cnt        <= '0;
      r_reload_pending <= 1'b0;
      r_rx_holding     <= '0;
      r_miso           <= 1'b1;
      r_miso_oe        <= 1'b0;
    end else begin
      r_tx_shift <= w_tx_next;
      r_miso_oe  <= (w_state_n == SPI_SHIFT);
      if (w_load_tx || w_shift_tx) r_miso <= w_tx_next[7];
      if (w_rx_en) r_rx_shift <= {r_rx_shift[5:0], w_s_mosi};
      if (w_byte_done) r_rx_holding <= {r_rx_shift, w_s_mosi};
      if (r_state == SPI_IDLE || w_frame_end) r_bit_cnt <= 3'd0;
      else if (w_rx_en)                       r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_frame_end)      r_reload_pending <= 1'b0;
      else if (w_byte_done) r_reload_pending <= 1'b1;
      else if (w_load_tx)   r_reload_pending <= 1'b0;
    end
  end

  // TX holding, flags and control. Flag sets take priority over clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_holding <= '0;
      r_tx_primed  <= 1'b0;
      r_rrdy       <= 1'b0;
      r_roe        <= 1'b0;
      r_tur        <= 1'b0;
      r_fe         <= 1'b0;
      r_control    <= '0;
    end else begin
      // A load and a CPU write in the same cycle: the load uses the old
      // byte (w_tx_src), and the new byte stays primed.
      if (w_wr_tx) begin
        r_tx_holding <= data_from_cpu[7:0];
        r_tx_primed  <= 1'b1;
      end else if (w_load_tx && r_tx_primed) begin
        r_tx_primed <= 1'b0;
      end

      if (w_load_tx && !r_tx_primed) r_tur <= 1'b1;
      else if (w_wr_status)          r_tur <= 1'b0;

      if (w_byte_done && r_rrdy && !w_rd_rx) r_roe <= 1'b1;
      else if (w_wr_status)                  r_roe <= 1'b0;

      if (w_abort)          r_fe <= 1'b1;
      else if (w_wr_status) r_fe <= 1'b0;

      if (w_byte_done)  r_rrdy <= 1'b1;
      else if (w_rd_rx) r_rrdy <= 1'b0;

      if (w_wr_ctrl) r_control <= data_from_cpu;
    end
  end

  assign w_status = pack_status(r_rrdy, ~r_tx_primed, r_tur, r_roe, r_fe, ~w_s_ss);

  always_comb begin
    w_rd_data = '0;
    case (mem_addr)
      ADDR_RXDATA:  w_rd_data = {8'h00, r_rx_holding};
      ADDR_STATUS:  w_rd_data = w_status;
      ADDR_CONTROL: w_rd_data = r_control;
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_to_cpu <= '0;
      r_irq         <= 1'b0;
    end else begin
      if (w_rd) r_data_to_cpu <= w_rd_data;
      r_irq <= |(w_status[7:2] & r_control[7:2]);
    end
  end

  assign MISO          = r_miso;
  assign MISO_oe       = r_miso_oe;
  assign data_to_cpu   = r_data_to_cpu;
  assign irq           = r_irq;
  assign dataavailable = r_rrdy;
  assign readyfordata  = ~r_tx_primed;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - self-checking bench for spi_slave_port
module tb_spi_slave_port;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, MISO_oe;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0000;
  logic [15:0] data_to_cpu;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic        spi_select = 1'b0;
  logic        irq, dataavailable, readyfordata;

  always #5 clk = ~clk;

  spi_slave_port #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
    .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model of the slave
  logic [7:0] m_hold = 8'h00;
  bit         m_primed = 0, m_tur = 0, m_roe = 0, m_fe = 0;
  int         m_bits = 0;
  logic [7:0] m_rx_q[$];    // bytes the CPU should read (scoreboard)
  logic [7:0] m_miso_q[$];  // bytes the master should see on MISO

  typedef struct {
    logic [7:0]  mosi;
    bit          prime;
    logic [7:0]  tx;
    logic [7:0]  exp_miso;
    logic [15:0] exp_status;  // status while SCLK is held high after bit 8
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_load();
    if (m_primed) begin
      m_primed = 0;
      return m_hold;
    end
    m_tur = 1;
    return 8'hFF;
  endfunction

  function automatic logic [15:0] model_status();
    return {8'h00, (m_rx_q.size() != 0), ~m_primed, 1'b0, m_tur, m_roe, m_fe, 1'b0, ~SS_n};
  endfunction

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    tick(1);
    spi_select = 1'b0; write_n = 1'b1;
    if (a == ADDR_TXDATA) begin m_hold = d[7:0]; m_primed = 1; end
    if (a == ADDR_STATUS) begin m_tur = 0; m_roe = 0; m_fe = 0; end
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    tick(1);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
  endtask

  task automatic check_status(input string name, output logic [15:0] d);
    logic [15:0] e;
    e = model_status();
    reg_read(ADDR_STATUS, d);
    check(name, d, e);
  endtask

  task automatic read_rx(input string name);
    logic [15:0] d;
    reg_read(ADDR_RXDATA, d);
    if (m_rx_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got %h, required no unread byte", name, d);
    end else begin
      check(name, d, {8'h00, m_rx_q.pop_front()});
    end
  endtask

  task automatic wait_sig(input bit sel, input string name);
    int i;
    for (i = 0; i < 4000; i++) begin
      if ((sel ? dataavailable : readyfordata) === 1'b1) break;
      tick(1);
    end
    if (i == 4000) begin
      n_total++;
      $display("FAIL %s: got 0 after 4000 cycles, required 1", name);
    end
  endtask

  // SPI master: SCLK = clk/16, 8 clk per phase
  task automatic ss_begin();
    SS_n = 1'b0;
    m_miso_q.push_back(model_load());
    m_bits = 0;
    tick(8);
  endtask

  // Sends n bits of m MSB first. A full byte with last=1 leaves SCLK high.
  task automatic spi_bits(input logic [7:0] m, input int n, input bit last,
                          output logic [7:0] cap);
    logic [7:0] e;
    cap = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = m[7-i];
      tick(8);
      cap = {cap[6:0], MISO};
      SCLK = 1'b1;
      m_bits = (m_bits + 1) % 8;
      if (m_bits == 0) begin
        if (m_rx_q.size() != 0) begin m_roe = 1; m_rx_q.delete(); end
        m_rx_q.push_back(m);
      end
      tick(8);
      if (!(last && i == n - 1)) SCLK = 1'b0;
    end
    if (m_miso_q.size() == 0) begin
      n_total++;
      $display("FAIL miso_sb: got %h, required no transfer", cap);
    end else begin
      e = m_miso_q.pop_front();
      check("miso_sb", {8'h00, cap}, {8'h00, e >> (8 - n)});
    end
    if (n == 8 && !last) m_miso_q.push_back(model_load());
  endtask

  task automatic ss_close();
    if (SCLK) begin
      SCLK = 1'b0;
      void'(model_load());
      tick(8);
    end
    if (m_bits != 0) m_fe = 1;
    m_bits = 0;
    SS_n = 1'b1;
    tick(8);
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] cap;
    logic [15:0] d;

    vecs[0] = '{mosi: 8'h3C, prime: 1, tx: 8'hA5, exp_miso: 8'hA5, exp_status: 16'h00C1};
    vecs[1] = '{mosi: 8'h00, prime: 1, tx: 8'hFF, exp_miso: 8'hFF, exp_status: 16'h00C1};
    vecs[2] = '{mosi: 8'hFF, prime: 1, tx: 8'h00, exp_miso: 8'h00, exp_status: 16'h00C1};
    vecs[3] = '{mosi: 8'h96, prime: 0, tx: 8'h00, exp_miso: 8'hFF, exp_status: 16'h00D1};
    vecs[4] = '{mosi: 8'h5A, prime: 1, tx: 8'h81, exp_miso: 8'h81, exp_status: 16'h00C1};

    // Reset state
    tick(3);
    check("rst_miso", MISO, 1);
    check("rst_oe", MISO_oe, 0);
    check("rst_rdata", data_to_cpu, 16'h0000);
    check("rst_irq", irq, 0);
    check("rst_rrdy", dataavailable, 0);
    check("rst_trdy", readyfordata, 1);
    reset_n = 1'b1;
    tick(2);
    check_status("rst_status", d);
    check("rst_status_const", d, 16'h0040);

    // Single-byte frames from the table
    for (int v = 0; v < 5; v++) begin
      reg_write(ADDR_STATUS, 16'h0000);
      if (vecs[v].prime) begin
        reg_write(ADDR_TXDATA, {8'h00, vecs[v].tx});
        check("vec_trdy_primed", readyfordata, 0);
      end
      ss_begin();
      check("vec_trdy_after_ss", readyfordata, 1);
      check("vec_oe_on", MISO_oe, 1);
      spi_bits(vecs[v].mosi, 8, 1, cap);
      check("vec_miso", {8'h00, cap}, {8'h00, vecs[v].exp_miso});
      reg_read(ADDR_STATUS, d);
      check("vec_status", d, vecs[v].exp_status);
      read_rx("vec_rx");
      ss_close();
      check("vec_oe_off", MISO_oe, 0);
    end

    // Back-to-back bytes in one frame; second byte primed once TRDY rises
    reg_write(ADDR_STATUS, 16'h0000);
    reg_write(ADDR_TXDATA, 16'h0011);
    fork
      begin
        ss_begin();
        spi_bits(8'hC0, 8, 0, cap);
        spi_bits(8'h0F, 8, 1, cap);
      end
      begin
        wait_sig(0, "b2b_trdy_wait");
        reg_write(ADDR_TXDATA, 16'h0022);
        wait_sig(1, "b2b_rrdy_wait");
        read_rx("b2b_rx0");
      end
    join
    check_status("b2b_status", d);
    check("b2b_roe", d[ST_ROE], 0);
    read_rx("b2b_rx1");
    ss_close();

    // Underrun and overrun
    reg_write(ADDR_STATUS, 16'h0000);
    ss_begin();
    spi_bits(8'hA7, 8, 0, cap);
    spi_bits(8'hE1, 8, 1, cap);
    check_status("uo_status", d);
    check("uo_status_const", d, 16'h00D9);
    reg_write(ADDR_STATUS, 16'h0000);
    check_status("uo_cleared", d);
    check("uo_cleared_const", d, 16'h00C1);
    ss_close();
    read_rx("uo_rx");

    // Frame abort after 5 bits, with an unread byte pending
    reg_write(ADDR_STATUS, 16'h0000);
    ss_begin();
    spi_bits(8'h6B, 8, 1, cap);
    ss_close();
    ss_begin();
    spi_bits(8'hB4, 5, 0, cap);
    ss_close();
    check("fe_oe", MISO_oe, 0);
    check_status("fe_status", d);
    check("fe_bit", d[ST_FE], 1);
    read_rx("fe_prev_rx");
    reg_write(ADDR_TXDATA, 16'h003E);
    ss_begin();
    spi_bits(8'h29, 8, 1, cap);
    read_rx("fe_next_rx");
    ss_close();

    // Interrupt on RRDY
    reg_write(ADDR_STATUS, 16'h0000);
    reg_write(ADDR_CONTROL, 16'h0080);
    reg_write(ADDR_TXDATA, 16'h005C);
    check("irq_idle", irq, 0);
    fork
      begin
        ss_begin();
        spi_bits(8'hD2, 8, 1, cap);
      end
      begin
        wait_sig(1, "irq_rrdy_wait");
        check("irq_at_rrdy", irq, 0);
        tick(1);
        check("irq_after_rrdy", irq, 1);
      end
    join
    read_rx("irq_rx");
    tick(1);
    check("irq_cleared", irq, 0);
    reg_write(ADDR_CONTROL, 16'h0000);
    ss_close();

    // Reset in the middle of a byte
    reg_write(ADDR_TXDATA, 16'h0099);
    ss_begin();
    spi_bits(8'hC5, 3, 0, cap);
    reset_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b0;
    tick(2);
    m_primed = 0; m_tur = 0; m_roe = 0; m_fe = 0; m_bits = 0;
    m_rx_q.delete();
    m_miso_q.delete();
    check("mrst_miso", MISO, 1);
    check("mrst_oe", MISO_oe, 0);
    check("mrst_irq", irq, 0);
    check("mrst_rrdy", dataavailable, 0);
    check("mrst_trdy", readyfordata, 1);
    check("mrst_rdata", data_to_cpu, 16'h0000);
    reset_n = 1'b1;
    tick(4);
    check_status("mrst_status", d);
    check("mrst_status_const", d, 16'h0040);
    reg_write(ADDR_TXDATA, 16'h00C8);
    ss_begin();
    spi_bits(8'h71, 8, 1, cap);
    check("mrst_next_miso", {8'h00, cap}, 16'h00C8);
    read_rx("mrst_next_rx");
    ss_close();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave peripheral (mode 0: CPOL=0, CPHA=0, 8-bit, MSB first) with an Avalon-MM register port, interrupt and streaming ready flags.
- Lets the SoC respond to an external SPI master, such as a second board or a test controller, using the same register semantics as our SPI master peripheral.
- SCLK, SS_n and MOSI are asynchronous inputs. They are synchronized into clk and processed by edge detection; the block has no SCLK clock domain.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK/SS_n/MOSI (min 2).
- IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is primed (underrun).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_oe  out  1  MISO output enable (tri-state control at the top level).
- mem_addr  in  3  register address.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- read_n  in  1  read strobe, active low.
- write_n  in  1  write strobe, active low.
- spi_select  in  1  chip select for the register port.
- irq  out  1  registered interrupt.
- dataavailable  out  1  equals RRDY.
- readyfordata  out  1  equals TRDY.

Behaviour:
- Reset:
  - All registers clear.
  - MISO=1, MISO_oe=0, data_to_cpu=0, irq=0, RRDY=0, TRDY=1.
  - Synchronizer flops are set to SCLK=0, SS_n=1.
- Register map:
  - 0 rxdata (r).
  - 1 txdata (w).
  - 2 status (r; any write clears ROE/TUR/FE).
  - 3 control (r/w; irq enables in the same bit positions as status).
- Status bits: 7 RRDY, 6 TRDY, 4 TUR (tx underrun), 3 ROE (rx overrun), 2 FE (frame abort), 0 SSACT (synced SS active). All other bits read 0.
- Register access:
  - Write: spi_select & ~write_n, single cycle.
  - Read: data_to_cpu is registered from the mux on mem_addr, so it is valid the cycle after the request.
  - A read at addr 0 clears RRDY on the cycle of the request.
- Synchronization and edges:
  - Each input passes through SYNC_STAGES flops, plus one history flop on SCLK and SS_n.
  - rise = s_sclk & ~h_sclk; fall = ~s_sclk & h_sclk; ss_start = ~s_ss & h_ss; ss_end = s_ss & ~h_ss.
  - Latency from a pin edge to the internal edge pulse is SYNC_STAGES+1 clk.
  - Required: SCLK high and low phases each >= SYNC_STAGES+3 clk.
- FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on ss_start:
    - load tx_shift from tx_holding if primed (clear primed), else from IDLE_BYTE and set TUR;
    - bit_cnt=0; MISO_oe=1; MISO=tx_shift[7].
  - SHIFT, on rise: rx_shift <= {rx_shift[6:0], s_mosi}; bit_cnt++.
  - SHIFT, on rise with bit_cnt==7:
    - rx_holding <= completed byte; RRDY<=1; ROE<=1 if RRDY was already 1 (new byte overwrites);
    - bit_cnt wraps to 0; set flag reload_pending.
  - SHIFT, on fall:
    - if reload_pending: reload tx_shift as for ss_start (primed byte or IDLE_BYTE with TUR) and clear reload_pending;
    - otherwise shift tx_shift left by one.
    - MISO = tx_shift[7] after the update. This gives back-to-back bytes within one SS frame.
  - SHIFT -> IDLE on ss_end:
    - if bit_cnt!=0, set FE and discard the partial byte (rx_holding and RRDY unchanged);
    - MISO_oe=0; bit_cnt=0; reload_pending=0.
  - An ss_end on the same cycle as a rise: the rise is processed first, then the transition to IDLE.
- TX holding:
  - TRDY = ~tx_primed.
  - A write to addr 1 loads data_from_cpu[7:0] and sets primed.
  - A write when primed overwrites the byte and leaves primed set (no error flag).
  - A CPU write on the same cycle as a load into tx_shift: the load takes the old byte, then the new byte is primed.
- irq:
  - irq_reg <= |(status[7:2] & control[7:2]), registered.
  - irq drops one cycle after the causing flag clears.
- Status/flag collisions:
  - A status write on the same cycle as a flag set: the set wins.
  - An rxdata read on the same cycle as a byte completion: RRDY stays 1, ROE is not set.

Decomposition:
- Shared package spi_pkg: register addresses (ADDR_RXDATA..ADDR_CONTROL), status bit indices, SPI mode constants (shared with the master).
- Sub-module spi_sync_edge: synchronizer plus edge detect for one input, parameterized by SYNC_STAGES. It is instantiated for SCLK and SS_n. MOSI uses the synchronizer only (no history flop).

Test Plan:
- Single byte:
  - Stimulus: write txdata=8'hA5; master sends 8'h3C at SCLK=clk/16.
  - Required: MISO bit stream 10100101; rx=8'h3C; RRDY=1; TUR=0; TRDY=1 after SS falls.
- Back-to-back:
  - Stimulus: prime 8'h11, then 8'h22 after TRDY rises; master sends 8'hC0, 8'h0F in one SS frame.
  - Required: MISO carries 11h then 22h; CPU reads C0h then 0Fh; ROE=0.
- Underrun and overrun:
  - Stimulus: no TX byte primed; master sends two bytes; CPU does not read.
  - Required: MISO=FFh for both bytes; TUR=1; ROE=1; rx=second byte.
  - Then write status -> TUR, ROE, FE all 0; RRDY unchanged.
- Frame abort:
  - Stimulus: SS_n rises after 5 SCLK rises.
  - Required: FE=1; RRDY unchanged; MISO_oe=0.
  - The next full frame is received correctly.
- Interrupt:
  - Stimulus: control=8'h80; complete one byte.
  - Required: irq=1 one clk after RRDY rises; read rxdata -> irq=0 within 2 clk.
- Reset mid-byte:
  - Stimulus: reset_n low after 3 bits.
  - Required: all flags 0, MISO_oe=0, MISO=1, IDLE state.
  - The following frame is received correctly.
